// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the four requesters, the arbiter and the 4:1 mux select.
// valid qualifies gnt and {s1,s0}: the mux output is usable only while valid=1, and consumers must not use it in the valid=0 cycle that separates two grants.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       valid;
  logic       s0;
  logic       s1;

  // Requester side: raises req, observes grant and select.
  modport master (
    output req,
    input  gnt,
    input  valid,
    input  s0,
    input  s1
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output valid,
    output s0,
    output s1
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// 4-channel round-robin arbiter driving the select lines of a 4:1 mux.
// Each grant has bounded hold time and is followed by a one-cycle break-before-make gap.
module mux_sel_arbiter #(
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux_sel_arbiter_if.slave  bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [1:0]       sel_q, sel_d;

  logic [1:0]       win;
  logic             any_req;
  logic [1:0]       idx;
  logic             rel_min;
  logic             rel_max;

  // Round-robin scan starting just after the last released channel.
  always_comb begin
    win     = ptr_q;
    any_req = 1'b0;
    idx     = ptr_q;
    for (int i = 1; i < 5; i++) begin
      idx = 2'(ptr_q + 2'(i));
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  // sel_q always holds the current grant index while in GRANT.
  assign rel_min = (cnt_q >= MIN_LAST) && !bus.req[sel_q];
  assign rel_max = (cnt_q >= MAX_LAST) && ((bus.req & ~gnt_q) != 4'b0000);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    case (state_q)
      GRANT: begin
        if (rel_min || rel_max) begin
          state_d = GAP;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          ptr_d   = sel_q;
        end else if (cnt_q != MAX_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; GAP falls back to IDLE when nobody asks.
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          valid_d = 1'b1;
          sel_d   = win;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign state_o   = state_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: hand-derived vector table, scoreboard queue, invariant checks and a random soak.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(
    .MIN_HOLD (2),
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] sel;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  int         total;
  int         bad;
  logic [3:0] prev_gnt;
  int         run_len;

  function automatic void add(input logic r, input logic [3:0] q,
                              input logic [3:0] g, input logic v, input logic [1:0] s);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.valid = v; t.sel = s;
    vecs.push_back(t);
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endfunction

  // Invariants that must hold after every edge, independent of stimulus.
  task automatic check_inv(input logic was_rst);
    logic [3:0] g;
    g = bus.gnt;
    check("onehot_or_zero", 32'((g & (g - 4'd1)) == 4'd0), 32'd1);
    check("valid_eq_or_gnt", 32'(bus.valid), 32'(|g));
    if (bus.valid) begin
      check("sel_matches_gnt", 32'(4'b0001 << {bus.s1, bus.s0}), 32'(g));
      check("state_grant", 32'(dbg_state), 32'd1);
    end
    if (!was_rst && prev_gnt != 4'd0 && g != 4'd0)
      check("break_before_make", 32'(g), 32'(prev_gnt));
    if (was_rst) begin
      run_len = 0;
    end else if (g != 4'd0) begin
      run_len++;
    end else begin
      if (prev_gnt != 4'd0) check("min_hold", 32'(run_len >= 2), 32'd1);
      run_len = 0;
    end
    prev_gnt = g;
  endtask

  // Driver: apply one cycle of inputs, queue the expected outputs, score after the edge.
  task automatic step(input vec_t v, input int n);
    logic [6:0] got;
    logic [6:0] want;
    rst     = v.rst;
    bus.req = v.req;
    exp_q.push_back({v.gnt, v.valid, v.sel});
    @(posedge clk);
    #1;
    got  = {bus.gnt, bus.valid, bus.s1, bus.s0};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL vec%0d: got gnt=%b valid=%b sel=%b expected gnt=%b valid=%b sel=%b",
               n, got[6:3], got[2], got[1:0], want[6:3], want[2], want[1:0]);
    end
    check_inv(v.rst);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prev_gnt = 4'd0;
    run_len  = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;

    // Reset with all requests up, then full round robin: 4-cycle grants, 1-cycle gaps.
    add(1, 4'b1111, 4'b0000, 0, 2'd0);
    add(1, 4'b1111, 4'b0000, 0, 2'd0);
    add(0, 4'b1111, 4'b0001, 1, 2'd0);
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0001, 1, 2'd0);
    add(0, 4'b1111, 4'b0000, 0, 2'd0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0010, 1, 2'd1);
    add(0, 4'b1111, 4'b0000, 0, 2'd1);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0100, 1, 2'd2);
    add(0, 4'b1111, 4'b0000, 0, 2'd2);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b1000, 1, 2'd3);
    add(0, 4'b1111, 4'b0000, 0, 2'd3);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0001, 1, 2'd0);
    // All requests drop at cnt=3: release, gap, idle.
    add(0, 4'b0000, 4'b0000, 0, 2'd0);
    add(0, 4'b0000, 4'b0000, 0, 2'd0);

    // Single one-cycle request: held for the minimum 2 cycles, select kept through gap and idle.
    add(0, 4'b0100, 4'b0100, 1, 2'd2);
    add(0, 4'b0000, 4'b0100, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, 0, 2'd2);
    add(0, 4'b0000, 4'b0000, 0, 2'd2);
    add(0, 4'b0000, 4'b0000, 0, 2'd2);

    // Sole requester keeps the grant; a second requester pre-empts at saturated count.
    for (int i = 0; i < 10; i++) add(0, 4'b0001, 4'b0001, 1, 2'd0);
    add(0, 4'b0101, 4'b0000, 0, 2'd0);
    add(0, 4'b0101, 4'b0100, 1, 2'd2);

    // Request rising on the release edge is seen by the gap; then wrap-around ch3 -> ch0.
    add(0, 4'b0000, 4'b0100, 1, 2'd2);
    add(0, 4'b1000, 4'b0000, 0, 2'd2);
    add(0, 4'b1000, 4'b1000, 1, 2'd3);
    add(0, 4'b0000, 4'b1000, 1, 2'd3);
    add(0, 4'b0000, 4'b0000, 0, 2'd3);
    add(0, 4'b1001, 4'b0001, 1, 2'd0);

    // Just-released channel wins the gap again when it is the only requester.
    add(0, 4'b0000, 4'b0001, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 0, 2'd0);
    add(0, 4'b0001, 4'b0001, 1, 2'd0);

    // Reset mid-grant (gnt=0010, cnt=1), then a fresh grant that restarts the count.
    add(0, 4'b0000, 4'b0001, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 0, 2'd0);
    add(0, 4'b0010, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 4'b0010, 1, 2'd1);
    add(1, 4'b0010, 4'b0000, 0, 2'd0);
    add(0, 4'b0010, 4'b0010, 1, 2'd1);
    add(0, 4'b0000, 4'b0010, 1, 2'd1);
    add(0, 4'b0000, 4'b0000, 0, 2'd1);
    add(0, 4'b0000, 4'b0000, 0, 2'd1);

    // Min-hold and max-hold release true together: exactly one release.
    add(0, 4'b0001, 4'b0001, 1, 2'd0);
    for (int i = 0; i < 3; i++) add(0, 4'b0001, 4'b0001, 1, 2'd0);
    add(0, 4'b0010, 4'b0000, 0, 2'd0);
    add(0, 4'b0010, 4'b0010, 1, 2'd1);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Random soak: invariants only.
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      rst     = 1'b0;
      bus.req = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      v.rst = 1'b0;
      check_inv(v.rst);
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
